neo_multich: RTL and testbench

NEO_MULTICH -- requirements
Module: neo_multich

---
 rtl/neo_multich.sv | 141 ++++++++++++++
 tb/tb_neo_multich.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neo_multich.sv
// Time-interleaved multichannel k-NEO operator: y[n] = x[n-k]^2 - x[n]*x[n-2k] per channel,
// with a single-entry output register, ready/valid handshakes and a registered spike flag.
module neo_multich #(
    parameter int DATA_W = 8,
    parameter int CH = 2,
    parameter int K_MAX = 4,
    localparam int KW = $clog2(K_MAX + 1),
    localparam int CW = (CH > 1) ? $clog2(CH) : 1,
    localparam int OW = 2 * DATA_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [KW-1:0]            k_sel,
    input  logic signed [OW-1:0]     threshold,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OW-1:0]     out_data,
    output logic [CW-1:0]            out_ch,
    output logic                     spike
);

    localparam int DEPTH = 2 * K_MAX;
    // 2k never exceeds 2*K_MAX, which always fits in KW+1 bits
    localparam int NW = KW + 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]               state;
    logic [KW-1:0]            k_q;
    logic [KW-1:0]            k_lat;
    logic [CW-1:0]            ptr;
    logic signed [DATA_W-1:0] hist [CH][DEPTH];
    logic [NW-1:0]            cnt [CH];
    logic [NW-1:0]            two_k;
    logic [NW-1:0]            cur_cnt;
    logic signed [DATA_W-1:0] x_k;
    logic signed [DATA_W-1:0] x_2k;
    logic signed [OW-1:0]     xe;
    logic signed [OW-1:0]     xke;
    logic signed [OW-1:0]     x2ke;
    logic signed [OW-1:0]     y;
    logic                     accept;
    logic                     full;

    always_comb begin
        in_ready = !rst && (state == RUN) && enable && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        two_k    = {k_q, 1'b0};
        cur_cnt  = '0;
        x_k      = '0;
        x_2k     = '0;
        // hist[c][0] holds x[n-1], so x[n-k] sits at index k-1
        for (int c = 0; c < CH; c++) begin
            if (c == int'(ptr)) begin
                cur_cnt = cnt[c];
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == int'(k_q) - 1)     x_k  = hist[c][j];
                    if (j == 2 * int'(k_q) - 1) x_2k = hist[c][j];
                end
            end
        end
        full = (cur_cnt == two_k);
        xe   = {{(OW - DATA_W){in_data[DATA_W-1]}}, in_data};
        xke  = {{(OW - DATA_W){x_k[DATA_W-1]}}, x_k};
        x2ke = {{(OW - DATA_W){x_2k[DATA_W-1]}}, x_2k};
        y    = xke * xke - xe * x2ke;
    end

    always_comb begin
        if (k_sel == '0) begin
            k_lat = KW'(1);
        end else if (k_sel > KW'(K_MAX)) begin
            k_lat = KW'(K_MAX);
        end else begin
            k_lat = k_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k_q       <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            spike     <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                cnt[c] <= '0;
                for (int j = 0; j < DEPTH; j++) hist[c][j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        k_q   <= k_lat;
                        ptr   <= '0;
                        for (int c = 0; c < CH; c++) begin
                            cnt[c] <= '0;
                            for (int j = 0; j < DEPTH; j++) hist[c][j] <= '0;
                        end
                    end
                end
                default: begin
                    if (!enable && !out_valid) state <= IDLE;
                end
            endcase

            // accept is only possible in RUN, so it never collides with the IDLE clear
            if (accept) begin
                for (int c = 0; c < CH; c++) begin
                    if (c == int'(ptr)) begin
                        hist[c][0] <= in_data;
                        for (int j = 1; j < DEPTH; j++) hist[c][j] <= hist[c][j-1];
                        if (!full) cnt[c] <= cnt[c] + NW'(1);
                    end
                end
                if (int'(ptr) == CH - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= ptr + CW'(1);
                end
            end

            if (accept && full) begin
                out_valid <= 1'b1;
                out_data  <= y;
                out_ch    <= ptr;
                spike     <= (y > threshold);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neo_multich.sv
// Directed bench for neo_multich: hand-computed results are queued by the stimulus and
// popped by an independent monitor on every output handshake.
module tb_neo_multich;

    localparam int DATA_W = 8;
    localparam int CH = 2;
    localparam int K_MAX = 4;
    localparam int KW = 3;
    localparam int CW = 1;
    localparam int OW = 17;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic [KW-1:0]            k_sel;
    logic signed [OW-1:0]     threshold;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OW-1:0]     out_data;
    logic [CW-1:0]            out_ch;
    logic                     spike;

    typedef struct {
        logic signed [OW-1:0] d;
        logic [CW-1:0]        c;
        logic                 s;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    neo_multich #(
        .DATA_W(DATA_W),
        .CH    (CH),
        .K_MAX (K_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .k_sel    (k_sel),
        .threshold(threshold),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ch   (out_ch),
        .spike    (spike)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_res(input longint d, input int c, input bit s);
        exp_t e;
        e.d = OW'(d);
        e.c = CW'(c);
        e.s = s;
        sb.push_back(e);
    endtask

    task automatic send(input int x);
        int t;
        t = 0;
        in_data  = DATA_W'(x);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic restart(input int k);
        enable    = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        k_sel  = KW'(k);
        enable = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got data=%0d ch=%0d, expected no output",
                         out_data, out_ch);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", out_data, mon_e.d);
                check("out_ch", out_ch, mon_e.c);
                check("spike", spike, mon_e.s);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        k_sel     = '0;
        threshold = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_spike", spike, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // k=1 stream with backpressure; k_sel change in RUN must be ignored
        restart(1);
        k_sel = 3'd3;
        send(1); send(10); send(2); send(20);
        expect_res(1, 0, 1);
        out_ready = 1'b0;
        send(3);
        repeat (3) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_data", out_data, 1);
            check("hold_out_ch", out_ch, 0);
            check("hold_spike", spike, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_res(100, 1, 1); send(30);
        expect_res(1, 0, 1);   send(4);
        expect_res(100, 1, 1); send(40);

        // k_sel=7 clamps to K_MAX=4
        restart(7);
        for (int i = 1; i <= 8; i++) begin
            send(i);
            send(0);
        end
        expect_res(16, 0, 1); send(9);
        expect_res(0, 1, 0);  send(0);

        // k_sel=0 latches as 1; extreme operands
        restart(0);
        send(127); send(0); send(-128); send(0);
        expect_res(32640, 0, 1); send(-128);
        expect_res(0, 1, 0);     send(0);
        restart(1);
        send(-128); send(0); send(0); send(0);
        expect_res(-16384, 0, 0); send(-128);
        expect_res(0, 1, 0);      send(0);

        // strict threshold compare
        threshold = 17'sd100;
        restart(1);
        send(0); send(1); send(10); send(10);
        expect_res(100, 0, 0); send(0);
        expect_res(101, 1, 1); send(-1);
        repeat (2) @(posedge clk);
        #1;
        threshold = '0;

        // enable dropped with a result pending, then re-enabled
        restart(1);
        send(1); send(1); send(2); send(2);
        expect_res(1, 0, 1);
        out_ready = 1'b0;
        send(3);
        enable = 1'b0;
        @(negedge clk);
        check("en_drop_in_ready", in_ready, 0);
        check("en_drop_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        k_sel  = 3'd1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        send(5); send(5); send(6); send(6);
        expect_res(1, 0, 1); send(7);
        expect_res(1, 1, 1); send(7);

        // rst mid-stream with a result pending, k=2 warm-up afterwards
        restart(2);
        for (int i = 1; i <= 4; i++) begin
            send(i);
            send(0);
        end
        expect_res(4, 0, 1);
        out_ready = 1'b0;
        send(5);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready_comb", in_ready, 0);
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_ch", out_ch, 0);
        check("mid_rst_spike", spike, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        k_sel = 3'd2;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            send(i);
            send(0);
        end
        expect_res(4, 0, 1); send(5);
        expect_res(0, 1, 0); send(0);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
